// File: rtl/speed_to_timing_pkg.sv
// Shared definitions for the move-request to step-timing converter.
//   CLK_FREQ        : clk frequency in Hz; the numerator of every period.
//   P_* / NUM_PARAMS: slot indices of the params output vector.
//   state_t         : top-level FSM states.
//   calc_step_t     : which division the shared divider is working on.
//   min_u32         : unsigned minimum helper.
package speed_to_timing_pkg;

  localparam logic [31:0] CLK_FREQ = 32'd50_000_000;

  localparam int P_N        = 0;
  localparam int P_NN       = 1;
  localparam int P_T0       = 2;
  localparam int P_TNA      = 3;
  localparam int P_DELTA    = 4;
  localparam int NUM_PARAMS = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_T0,
    ST_TNA,
    ST_NN,
    ST_DELTA
  } calc_step_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_divider_64.sv
// Sequential restoring divider: 64-bit dividend / 32-bit divisor, one quotient
// bit per clock, 64 cycles per operation.
//   clk, reset : clock, synchronous active-high reset (also used to abort).
//   start      : accepted when not busy; operands are captured on that edge.
//   busy       : an operation is in progress.
//   done       : one-cycle pulse; quotient is valid from then until next start.
//   quotient   : 64-bit floor quotient; 0 when the divisor was 0.
module seq_divider_64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [63:0] quotient
);

  logic [63:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] div_q;
  logic [6:0]  count_q;
  logic [32:0] rem_shift;
  logic [32:0] rem_sub;

  // Partial remainder is always < divisor, so 32 bits hold it; the shifted
  // trial value needs one extra bit.
  assign rem_shift = {rem_q, quo_q[63]};
  assign rem_sub   = rem_shift - {1'b0, div_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      count_q <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        quo_q   <= dividend;
        rem_q   <= '0;
        div_q   <= divisor;
        count_q <= 7'd64;
        busy    <= 1'b1;
      end else if (busy) begin
        if (rem_shift >= {1'b0, div_q}) begin
          rem_q <= rem_sub[31:0];
          quo_q <= {quo_q[62:0], 1'b1};
        end else begin
          rem_q <= rem_shift[31:0];
          quo_q <= {quo_q[62:0], 1'b0};
        end
        count_q <= count_q - 7'd1;
        if (count_q == 7'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Division by zero runs the normal iterations but reports 0.
  assign quotient = (div_q == '0) ? '0 : quo_q;

endmodule

// File: rtl/speed_to_timing.sv
// Converts one axis's move request into a trapezoidal step-timing profile.
//   clk, reset   : clock, synchronous active-high reset.
//   start        : level request; inputs are latched on the first cycle high.
//   num          : signed step count (sign = direction).
//   speed        : cruise speed, steps/s.
//   acceleration : steps/s^2.
//   jerk         : start/stop speed, steps/s.
//   params       : [P_N] step count, [P_NN] ramp steps, [P_T0] start period,
//                  [P_TNA] cruise period, [P_DELTA] per-step decrement.
//   finish       : params valid; held while start stays high.
module speed_to_timing
  import speed_to_timing_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] num,
  input  logic        [31:0] speed,
  input  logic        [31:0] acceleration,
  input  logic        [31:0] jerk,
  output logic        [31:0] params [0:NUM_PARAMS-1],
  output logic               finish
);

  state_t      state_q, state_d;
  calc_step_t  step_q;
  logic        div_pending_q;
  logic        zero_q;
  logic [31:0] n_q, speed_q, accel_q, js_q;
  logic [31:0] t0_q, tna_q, nn_full_q;

  logic        div_reset, div_start, div_busy, div_done;
  logic [63:0] div_dividend, div_quotient;
  logic [31:0] div_divisor;

  logic [63:0] nn_half;
  logic [31:0] nn_sat;
  logic        last_step;
  logic        calc_done;
  logic [31:0] fin_nn_full, fin_delta, fin_nn, fin_dn, fin_tna;

  // Dropping start mid-calculation also flushes the divider so a new request
  // never sees a stale result.
  assign div_reset = reset || (state_q == S_CALC && !start);

  seq_divider_64 u_div (
    .clk      (clk),
    .reset    (div_reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // nn_full = (speed^2 - js^2) / (2*acc). 2*acc can exceed 32 bits, so divide
  // by acc and halve: floor(floor(x/a)/2) == floor(x/(2a)).
  assign nn_half   = div_quotient >> 1;
  assign nn_sat    = (nn_half[63:32] != '0) ? 32'hFFFF_FFFF : nn_half[31:0];
  assign last_step = (step_q == ST_DELTA) || (step_q == ST_NN && nn_sat == '0);

  // Final values, valid on the cycle calc_done is asserted.
  assign fin_nn_full = (step_q == ST_NN) ? nn_sat : nn_full_q;
  assign fin_delta   = (step_q == ST_DELTA) ? div_quotient[31:0] : '0;
  assign fin_nn      = min_u32(fin_nn_full, n_q >> 1);
  // delta*nn < t0 - tna whenever the ramp is truncated, so 32 bits suffice.
  assign fin_dn      = fin_delta * fin_nn;
  assign fin_tna     = (fin_nn < fin_nn_full) ? t0_q - fin_dn : tna_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    calc_done = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (zero_q) begin
          calc_done = 1'b1;
          state_d   = S_DONE;
        end else if (!div_pending_q) begin
          div_start = !div_busy;
        end else if (div_done && last_step) begin
          calc_done = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_dividend = '0;
    div_divisor  = '0;
    case (step_q)
      ST_T0: begin
        div_dividend = 64'(CLK_FREQ);
        div_divisor  = js_q;
      end
      ST_TNA: begin
        div_dividend = 64'(CLK_FREQ);
        div_divisor  = speed_q;
      end
      ST_NN: begin
        div_dividend = 64'(speed_q) * 64'(speed_q) - 64'(js_q) * 64'(js_q);
        div_divisor  = accel_q;
      end
      ST_DELTA: begin
        div_dividend = 64'(t0_q - tna_q);
        div_divisor  = nn_full_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q        <= ST_T0;
      div_pending_q <= 1'b0;
      zero_q        <= 1'b0;
      n_q           <= '0;
      speed_q       <= '0;
      accel_q       <= '0;
      js_q          <= '0;
      t0_q          <= '0;
      tna_q         <= '0;
      nn_full_q     <= '0;
      // NOTE: params is a small register bank, not a RAM, so it takes the
      // reset like any other flop.
      for (int i = 0; i < NUM_PARAMS; i++) params[i] <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        n_q     <= num[31] ? -num : num;
        speed_q <= speed;
        accel_q <= acceleration;
        // With no acceleration the ramp collapses: start speed = cruise speed,
        // which also makes the ramp-length dividend zero.
        js_q    <= (jerk == '0 || jerk > speed || acceleration == '0) ? speed : jerk;
        zero_q  <= (num == '0) || (speed == '0);
        step_q        <= ST_T0;
        div_pending_q <= 1'b0;
      end

      if (div_start) div_pending_q <= 1'b1;

      if (state_q == S_CALC && div_pending_q && div_done) begin
        div_pending_q <= 1'b0;
        case (step_q)
          ST_T0: begin
            t0_q   <= div_quotient[31:0];
            step_q <= ST_TNA;
          end
          ST_TNA: begin
            tna_q  <= div_quotient[31:0];
            step_q <= ST_NN;
          end
          ST_NN: begin
            nn_full_q <= nn_sat;
            step_q    <= ST_DELTA;
          end
          default: ;
        endcase
      end

      if (calc_done) begin
        params[P_N] <= n_q;
        if (zero_q) begin
          params[P_NN]    <= '0;
          params[P_T0]    <= '0;
          params[P_TNA]   <= '0;
          params[P_DELTA] <= '0;
        end else begin
          params[P_NN]    <= fin_nn;
          params[P_T0]    <= t0_q;
          params[P_TNA]   <= fin_tna;
          params[P_DELTA] <= fin_delta;
        end
      end
    end
  end

  assign finish = (state_q == S_DONE);

endmodule

// File: tb/tb_speed_to_timing.sv
// Self-checking bench for speed_to_timing: directed cases, handshake,
// abort, reset mid-calculation and randomized moves against a reference model.
module tb_speed_to_timing;
  import speed_to_timing_pkg::*;

  localparam int LAT_MAX = 300;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [31:0] num;
  logic        [31:0] speed;
  logic        [31:0] acceleration;
  logic        [31:0] jerk;
  logic        [31:0] params [0:NUM_PARAMS-1];
  logic               finish;

  int errors = 0;
  int checks = 0;

  speed_to_timing dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num          (num),
    .speed        (speed),
    .acceleration (acceleration),
    .jerk         (jerk),
    .params       (params),
    .finish       (finish)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0][31:0] mk_exp(input logic [31:0] n, input logic [31:0] nn,
                                              input logic [31:0] t0, input logic [31:0] tna,
                                              input logic [31:0] dl);
    return {dl, tna, t0, nn, n};
  endfunction

  // Reference model straight from the profile rules, using 64-bit arithmetic
  // and a true 2*acceleration divisor.
  function automatic logic [4:0][31:0] ref_model(input logic signed [31:0] n, input logic [31:0] sp,
                                                 input logic [31:0] acc, input logic [31:0] jk);
    logic [4:0][31:0] r;
    logic [31:0] nabs, js, t0, tna, nnf, nn, delta;
    logic [63:0] x;
    r = '0;
    nabs = n[31] ? -n : n;
    r[P_N] = nabs;
    if (n == 0 || sp == 0) return r;
    if (acc == 0) begin
      r[P_T0]  = CLK_FREQ / sp;
      r[P_TNA] = CLK_FREQ / sp;
      return r;
    end
    js  = (jk == 0 || jk > sp) ? sp : jk;
    t0  = CLK_FREQ / js;
    tna = CLK_FREQ / sp;
    x   = (64'(sp) * 64'(sp) - 64'(js) * 64'(js)) / (64'(acc) * 64'd2);
    nnf = (x > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : x[31:0];
    delta = (nnf != 0) ? (t0 - tna) / nnf : 32'd0;
    nn  = (nnf < nabs / 2) ? nnf : nabs / 2;
    if (nn < nnf) tna = t0 - delta * nn;
    r[P_NN] = nn;
    r[P_T0] = t0;
    r[P_TNA] = tna;
    r[P_DELTA] = delta;
    return r;
  endfunction

  task automatic launch(input logic signed [31:0] n, input logic [31:0] sp,
                        input logic [31:0] acc, input logic [31:0] jk);
    num = n;
    speed = sp;
    acceleration = acc;
    jerk = jk;
    start = 1'b1;
  endtask

  // Returns cycles after the edge that first samples start; bounded.
  task automatic wait_finish(output int lat);
    lat = 0;
    tick();
    while (!finish && lat < LAT_MAX) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_start();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    num = '0;
    speed = '0;
    acceleration = '0;
    jerk = '0;
    repeat (3) tick();
    checks++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL reset finish: got %b expected 0", finish);
    end
    for (int i = 0; i < NUM_PARAMS; i++) begin
      checks++;
      if (params[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset param[%0d]: got %0d expected 0", i, params[i]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic signed [31:0] vn  [9];
    logic        [31:0] vsp [9];
    logic        [31:0] vac [9];
    logic        [31:0] vjk [9];
    logic [4:0][31:0]   ve  [9];
    int lat;
    vn[0] = -1000;         vsp[0] = 1000;          vac[0] = 1000; vjk[0] = 500;
    ve[0] = mk_exp(1000, 375, 100000, 50000, 133);
    vn[1] = 200;           vsp[1] = 1000;          vac[1] = 1000; vjk[1] = 500;
    ve[1] = mk_exp(200, 100, 100000, 86700, 133);
    vn[2] = 500;           vsp[2] = 500;           vac[2] = 1000; vjk[2] = 800;
    ve[2] = mk_exp(500, 0, 100000, 100000, 0);
    vn[3] = 0;             vsp[3] = 1000;          vac[3] = 1000; vjk[3] = 500;
    ve[3] = mk_exp(0, 0, 0, 0, 0);
    vn[4] = 10;            vsp[4] = 1000;          vac[4] = 0;    vjk[4] = 500;
    ve[4] = mk_exp(10, 0, 50000, 50000, 0);
    vn[5] = 7;             vsp[5] = 0;             vac[5] = 1000; vjk[5] = 500;
    ve[5] = mk_exp(7, 0, 0, 0, 0);
    vn[6] = 32'sh7FFF_FFFF; vsp[6] = 32'hFFFF_FFFF; vac[6] = 1;    vjk[6] = 1;
    ve[6] = mk_exp(32'h7FFF_FFFF, 32'h3FFF_FFFF, 50000000, 50000000, 0);
    vn[7] = 1000;          vsp[7] = 1000;          vac[7] = 1000; vjk[7] = 0;
    ve[7] = mk_exp(1000, 0, 50000, 50000, 0);
    vn[8] = 32'sh8000_0000; vsp[8] = 1000;          vac[8] = 1000; vjk[8] = 500;
    ve[8] = mk_exp(32'h8000_0000, 375, 100000, 50000, 133);
    for (int v = 0; v < 9; v++) begin
      launch(vn[v], vsp[v], vac[v], vjk[v]);
      wait_finish(lat);
      checks++;
      if (finish !== 1'b1) begin
        errors++;
        $display("FAIL directed[%0d] finish within %0d: got %b after %0d cycles", v, LAT_MAX, finish, lat);
      end
      for (int i = 0; i < NUM_PARAMS; i++) begin
        checks++;
        if (params[i] !== ve[v][i]) begin
          errors++;
          $display("FAIL directed[%0d] param[%0d]: got %0d expected %0d", v, i, params[i], ve[v][i]);
        end
      end
      release_start();
    end
  endtask

  task automatic test_handshake();
    logic [4:0][31:0] e1, e2;
    int lat, drops;
    e1 = mk_exp(1000, 375, 100000, 50000, 133);
    e2 = mk_exp(200, 100, 100000, 86700, 133);
    launch(-1000, 1000, 1000, 500);
    wait_finish(lat);
    checks++;
    if (finish !== 1'b1) begin
      errors++;
      $display("FAIL handshake first finish: got %b after %0d cycles", finish, lat);
    end
    // Inputs change while held in DONE: nothing may be recomputed.
    num = 200;
    drops = 0;
    repeat (50) begin
      tick();
      if (finish !== 1'b1) drops++;
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL handshake hold: finish low on %0d cycles expected 0", drops);
    end
    for (int i = 0; i < NUM_PARAMS; i++) begin
      checks++;
      if (params[i] !== e1[i]) begin
        errors++;
        $display("FAIL handshake hold param[%0d]: got %0d expected %0d", i, params[i], e1[i]);
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL handshake drop finish: got %b expected 0", finish);
    end
    for (int i = 0; i < NUM_PARAMS; i++) begin
      checks++;
      if (params[i] !== e1[i]) begin
        errors++;
        $display("FAIL handshake retained param[%0d]: got %0d expected %0d", i, params[i], e1[i]);
      end
    end
    tick();
    // Second move; inputs are scrambled after they have been latched.
    launch(200, 1000, 1000, 500);
    tick();
    repeat (5) tick();
    num = 3;
    speed = 77;
    acceleration = 9;
    jerk = 1;
    lat = 6;
    while (!finish && lat < LAT_MAX) begin
      tick();
      lat++;
    end
    checks++;
    if (finish !== 1'b1) begin
      errors++;
      $display("FAIL handshake second finish: got %b after %0d cycles", finish, lat);
    end
    for (int i = 0; i < NUM_PARAMS; i++) begin
      checks++;
      if (params[i] !== e2[i]) begin
        errors++;
        $display("FAIL handshake second param[%0d]: got %0d expected %0d", i, params[i], e2[i]);
      end
    end
    release_start();
  endtask

  task automatic test_abort();
    logic [4:0][31:0] e_old, e_new;
    int lat, highs;
    e_old = mk_exp(200, 100, 100000, 86700, 133);
    e_new = mk_exp(500, 0, 100000, 100000, 0);
    launch(500, 500, 1000, 800);
    tick();
    repeat (100) tick();
    start = 1'b0;
    highs = 0;
    repeat (5) begin
      tick();
      if (finish !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL abort finish: high on %0d cycles expected 0", highs);
    end
    for (int i = 0; i < NUM_PARAMS; i++) begin
      checks++;
      if (params[i] !== e_old[i]) begin
        errors++;
        $display("FAIL abort retained param[%0d]: got %0d expected %0d", i, params[i], e_old[i]);
      end
    end
    launch(500, 500, 1000, 800);
    wait_finish(lat);
    checks++;
    if (finish !== 1'b1) begin
      errors++;
      $display("FAIL abort rerun finish: got %b after %0d cycles", finish, lat);
    end
    for (int i = 0; i < NUM_PARAMS; i++) begin
      checks++;
      if (params[i] !== e_new[i]) begin
        errors++;
        $display("FAIL abort rerun param[%0d]: got %0d expected %0d", i, params[i], e_new[i]);
      end
    end
    release_start();
  endtask

  task automatic test_reset_mid_calc();
    launch(-1000, 1000, 1000, 500);
    tick();
    repeat (40) tick();
    reset = 1'b1;
    start = 1'b0;
    tick();
    checks++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL reset mid-calc finish: got %b expected 0", finish);
    end
    for (int i = 0; i < NUM_PARAMS; i++) begin
      checks++;
      if (params[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset mid-calc param[%0d]: got %0d expected 0", i, params[i]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic signed [31:0] n;
    logic [31:0] sp, acc, jk;
    logic [4:0][31:0] e;
    int lat;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 7))
        0:       sp = 0;
        1:       sp = $urandom;
        default: sp = $urandom_range(1, 100000);
      endcase
      case ($urandom_range(0, 3))
        0:       jk = 0;
        1:       jk = (sp == 0) ? 32'd0 : $urandom_range(1, sp);
        2:       jk = sp + $urandom_range(1, 1000);
        default: jk = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       acc = 0;
        1:       acc = $urandom;
        default: acc = $urandom_range(1, 20000);
      endcase
      case ($urandom_range(0, 3))
        0:       n = int'($urandom_range(0, 2000)) - 1000;
        1:       n = $urandom;
        default: n = $urandom_range(1, 100000);
      endcase
      e = ref_model(n, sp, acc, jk);
      launch(n, sp, acc, jk);
      wait_finish(lat);
      checks++;
      if (finish !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] finish: got %b after %0d cycles", k, finish, lat);
      end
      for (int i = 0; i < NUM_PARAMS; i++) begin
        checks++;
        if (params[i] !== e[i]) begin
          errors++;
          $display("FAIL random[%0d] param[%0d] (num=%0d speed=%0d acc=%0d jerk=%0d): got %0d expected %0d",
                   k, i, n, sp, acc, jk, params[i], e[i]);
        end
      end
      release_start();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_abort();
    test_reset_mid_calc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
